// File: rtl/cordic_ci_master.sv
`timescale 1ns/1ps
// cordic_ci_master: drives the multi-cycle custom-instruction handshake of a
// CORDIC cosine slave from a valid/ready operand stream. One operation is in
// flight at a time. Results come back in order through a small result FIFO.
// Optional abort path: define CORDIC_CI_MASTER_TIMEOUT_EN to add the wait
// counter, the FLUSH state and the per-entry timeout flag.
module cordic_ci_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clock,
  input  logic        aclr_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        ci_aclr,
  output logic        ci_clk_en,
  output logic        ci_start,
  output logic [31:0] ci_dataa,
  input  logic [31:0] ci_result,
  input  logic        ci_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_timeout,
  output logic        busy
);

  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

`ifdef CORDIC_CI_MASTER_TIMEOUT_EN
  localparam int         EW       = 33;
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);
`else
  localparam int         EW       = 32;
`endif

  // Reject illegal configurations at elaboration rather than misbehave later.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cordic_ci_master: FIFO_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("cordic_ci_master: TIMEOUT must be in 2..255");
  end

`ifdef CORDIC_CI_MASTER_TIMEOUT_EN
  typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT, FLUSH} state_e;
`else
  typedef enum logic [1:0] {INIT, IDLE, ISSUE, WAIT} state_e;
`endif

  state_e      state_q;
  logic        init_q;     // INIT spends its first cycle idle, then pulses the clear
  logic [31:0] op_q;
  logic        aclr_q;
  logic        clken_q;
  logic        start_q;
  logic        busy_q;
`ifdef CORDIC_CI_MASTER_TIMEOUT_EN
  logic [7:0]  wcnt_q;
  logic        to_hit;
`endif

  // FIFO state
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q, cnt_d;
  logic          push, pop;
  logic [EW-1:0] push_ent;
  logic [EW-1:0] head;

  // done is only looked at in WAIT, so a level left over from the previous
  // operation can never complete the current one.
`ifdef CORDIC_CI_MASTER_TIMEOUT_EN
  assign to_hit   = (wcnt_q == TO_LIMIT);
  assign push     = (state_q == WAIT) && (ci_done || to_hit);
  assign push_ent = ci_done ? {1'b0, ci_result} : {1'b1, 32'h0};
`else
  assign push     = (state_q == WAIT) && ci_done;
  assign push_ent = ci_result;
`endif

  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign head      = mem[rptr_q];
  assign out_data  = out_valid ? head[31:0] : 32'h0;
`ifdef CORDIC_CI_MASTER_TIMEOUT_EN
  assign out_timeout = out_valid & head[32];
`else
  assign out_timeout = 1'b0;
`endif

  // Accepting only with a free slot guarantees the eventual push never stalls.
  assign in_ready  = (state_q == IDLE) && (cnt_q != FULL_CNT);

  assign ci_aclr   = aclr_q;
  assign ci_clk_en = clken_q;
  assign ci_start  = start_q;
  assign ci_dataa  = op_q;
  assign busy      = busy_q;

  // Control FSM; slave-facing strobes are registered for the state being entered.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= INIT;
      init_q  <= 1'b0;
      op_q    <= 32'h0;
      aclr_q  <= 1'b0;
      clken_q <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef CORDIC_CI_MASTER_TIMEOUT_EN
      wcnt_q  <= 8'd0;
`endif
    end else begin
      aclr_q  <= 1'b0;
      clken_q <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      case (state_q)
        INIT: begin
          if (!init_q) begin
            init_q  <= 1'b1;
            aclr_q  <= 1'b1;
            clken_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (in_valid && in_ready) begin
            op_q    <= in_data;
            state_q <= ISSUE;
            start_q <= 1'b1;
            clken_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
          clken_q <= 1'b1;
          busy_q  <= 1'b1;
`ifdef CORDIC_CI_MASTER_TIMEOUT_EN
          wcnt_q  <= 8'd1;
`endif
        end
        WAIT: begin
          if (ci_done) begin
            state_q <= IDLE;
`ifdef CORDIC_CI_MASTER_TIMEOUT_EN
          end else if (to_hit) begin
            state_q <= FLUSH;
            aclr_q  <= 1'b1;
            clken_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            wcnt_q  <= wcnt_q + 8'd1;
            clken_q <= 1'b1;
            busy_q  <= 1'b1;
`else
          end else begin
            clken_q <= 1'b1;
            busy_q  <= 1'b1;
`endif
          end
        end
`ifdef CORDIC_CI_MASTER_TIMEOUT_EN
        FLUSH: state_q <= IDLE;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  // Occupancy: simultaneous push and pop cancel out; pop is already gated by non-empty.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + (PW+1)'(1);
    else if (!push && pop) cnt_d = cnt_q - (PW+1)'(1);
  end

  // FIFO pointers and count; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clock) begin
    if (push) mem[wptr_q] <= push_ent;
  end

endmodule

// File: tb/tb_cordic_ci_master.sv
`timescale 1ns/1ps
module tb_cordic_ci_master;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic        clock = 1'b0;
  logic        aclr_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        ci_aclr, ci_clk_en, ci_start;
  logic [31:0] ci_dataa;
  logic [31:0] ci_result;
  logic        ci_done;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_timeout;
  logic        busy;

  cordic_ci_master #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clock(clock), .aclr_n(aclr_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ci_aclr(ci_aclr), .ci_clk_en(ci_clk_en), .ci_start(ci_start), .ci_dataa(ci_dataa),
    .ci_result(ci_result), .ci_done(ci_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_timeout(out_timeout), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave behaviour: cos(0.5) for the spec operand, a fixed scramble otherwise.
  function automatic logic [31:0] slave_fn(input logic [31:0] x);
    if (x == 32'h3F000000) return 32'h3F60A8B6;
    return {x[15:0], x[31:16]} ^ 32'h5A5A5A5A;
  endfunction

  // Slave model: done rises s_delay cycles after the cycle start was seen,
  // and stays high until the next start or clear.
  int unsigned s_delay = 9;
  bit          s_never = 1'b0;
  bit          force_done = 1'b0;
  logic        s_act, s_done;
  logic [31:0] s_res;
  int unsigned s_cnt;

  always @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      s_act <= 1'b0; s_done <= 1'b0; s_res <= 32'h0; s_cnt <= 0;
    end else if (ci_aclr) begin
      s_act <= 1'b0; s_done <= 1'b0; s_cnt <= 0;
    end else if (ci_clk_en && ci_start) begin
      s_act <= 1'b1; s_done <= 1'b0; s_cnt <= 1; s_res <= slave_fn(ci_dataa);
    end else if (s_act && ci_clk_en) begin
      s_cnt <= s_cnt + 1;
      if (!s_never && s_cnt >= s_delay - 1) begin
        s_done <= 1'b1; s_act <= 1'b0;
      end
    end
  end
  assign ci_done   = s_done | force_done;
  assign ci_result = force_done ? 32'hDEADBEEF : s_res;

  // Scoreboard: {timeout, data} expected per accepted operand, popped on output.
  logic [32:0] sb_q[$];

  always @(negedge clock) begin
    if (aclr_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) chk("sb_underflow", 64'(sb_q.size()), 64'd1);
      else chk("sb_result", 64'({out_timeout, out_data}), 64'(sb_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock); #2;
  endtask

  task automatic send(input logic [31:0] x, input int maxw, output bit ok);
    bit hs;
    ok = 1'b0;
    in_valid = 1'b1; in_data = x;
    for (int i = 0; i < maxw && !ok; i++) begin
      @(negedge clock); hs = in_ready;
      @(posedge clock); #2;
      if (hs) ok = 1'b1;
    end
    in_valid = 1'b0;
    if (ok) sb_q.push_back(s_never ? {1'b1, 32'h0} : {1'b0, slave_fn(x)});
  endtask

  task automatic wait_valid(input int maxc, output int c);
    c = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clock);
      if (out_valid) begin c = cyc; break; end
    end
  endtask

  task automatic drain(input int maxc);
    for (int i = 0; i < maxc && sb_q.size() != 0; i++) @(negedge clock);
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic count_aclr(input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clock);
      if (ci_aclr) begin
        n++;
        chk("aclr_clken", 64'(ci_clk_en), 64'd1);
        chk("aclr_no_ready", 64'(in_ready), 64'd0);
      end
    end
  endtask

  initial begin
    bit ok;
    int a0, a1, c, n;
    logic [31:0] x;

    // Reset state
    #1 aclr_n = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_ci_aclr", 64'(ci_aclr), 64'd0);
    chk("rst_ci_clk_en", 64'(ci_clk_en), 64'd0);
    chk("rst_ci_start", 64'(ci_start), 64'd0);
    chk("rst_ci_dataa", 64'(ci_dataa), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_timeout", 64'(out_timeout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    tick();
    aclr_n = 1'b1;
    count_aclr(6, n);
    chk("init_aclr_cycles", 64'(n), 64'd1);
    chk("init_in_ready", 64'(in_ready), 64'd1);
    tick();

    // Single operand against the D=9 slave: cycle-accurate latency
    out_ready = 1'b1; s_delay = 9;
    send(32'h3F000000, 10, ok);
    chk("t2_accept", 64'(ok), 64'd1);
    a0 = cyc;
    @(negedge clock);
    chk("t2_start_c1", 64'(ci_start), 64'd1);
    chk("t2_busy_c1", 64'(busy), 64'd1);
    chk("t2_in_ready_c1", 64'(in_ready), 64'd0);
    @(negedge clock);
    chk("t2_start_c2", 64'(ci_start), 64'd0);
    chk("t2_clken_c2", 64'(ci_clk_en), 64'd1);
    chk("t2_dataa_c2", 64'(ci_dataa), 64'h3F000000);
    wait_valid(40, c);
    chk("t2_out_valid_cycle", 64'(c - a0 + 1), 64'd11);
    chk("t2_out_data", 64'(out_data), 64'h3F60A8B6);
    chk("t2_out_timeout", 64'(out_timeout), 64'd0);
    tick();

    // Back-to-back operands: one per D+2 cycles
    s_delay = 3;
    send($urandom, 20, ok); a0 = cyc;
    send($urandom, 20, ok); a1 = cyc;
    chk("t3_period", 64'(a1 - a0), 64'd5);
    send($urandom, 20, ok);
    chk("t3_accept", 64'(ok), 64'd1);
    drain(60);
    tick();

    // Stale done held high before and during ISSUE must not complete the op
    s_delay = 4; force_done = 1'b1;
    repeat (3) tick();
    chk("t4_idle_no_push", 64'(out_valid), 64'd0);
    send(32'h12345678, 10, ok); a0 = cyc;
    @(negedge clock);
    chk("t4_start", 64'(ci_start), 64'd1);
    force_done = 1'b0;
    wait_valid(30, c);
    chk("t4_out_valid_cycle", 64'(c - a0 + 1), 64'd6);
    drain(20);
    tick();

    // Backpressure: four results buffered, then exactly one more per pop
    out_ready = 1'b0; s_delay = 2;
    for (int i = 0; i < DEPTH; i++) begin
      send($urandom, 20, ok);
      chk("t5_fill_accept", 64'(ok), 64'd1);
    end
    repeat (6) tick();
    @(negedge clock);
    chk("t5_full_valid", 64'(out_valid), 64'd1);
    chk("t5_full_in_ready", 64'(in_ready), 64'd0);
    tick();
    send($urandom, 15, ok);
    chk("t5_blocked", 64'(ok), 64'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    send(32'hCAFEF00D, 10, ok);
    chk("t5_one_more", 64'(ok), 64'd1);
    repeat (6) tick();
    send(32'h0BADF00D, 15, ok);
    chk("t5_blocked_again", 64'(ok), 64'd0);
    out_ready = 1'b1;
    drain(60);
    tick();

`ifdef CORDIC_CI_MASTER_TIMEOUT_EN
    // Slave never answers: abort entry at WAIT cycle TIMEOUT, then FLUSH
    s_never = 1'b1;
    send(32'h40490FDB, 10, ok); a0 = cyc;
    wait_valid(100, c);
    chk("t6_to_cycle", 64'(c - a0 + 1), 64'(TMO + 2));
    chk("t6_to_flag", 64'(out_timeout), 64'd1);
    chk("t6_to_data", 64'(out_data), 64'd0);
    chk("t6_flush_aclr", 64'(ci_aclr), 64'd1);
    chk("t6_flush_busy", 64'(busy), 64'd1);
    @(negedge clock);
    chk("t6_after_aclr", 64'(ci_aclr), 64'd0);
    chk("t6_after_ready", 64'(in_ready), 64'd1);
    s_never = 1'b0;
    tick();
    s_delay = 3;
    send(32'h3F800000, 10, ok);
    chk("t6_recover_accept", 64'(ok), 64'd1);
    drain(30);
`else
    // Without the abort path WAIT holds until done however long it takes
    s_delay = 100;
    send(32'h40490FDB, 10, ok); a0 = cyc;
    repeat (78) @(negedge clock);
    chk("t6_still_waiting", 64'(out_valid), 64'd0);
    chk("t6_still_busy", 64'(busy), 64'd1);
    wait_valid(40, c);
    chk("t6_late_cycle", 64'(c - a0 + 1), 64'd102);
    chk("t6_no_timeout", 64'(out_timeout), 64'd0);
    drain(20);
`endif
    tick();

    // Reset during WAIT with two entries buffered
    out_ready = 1'b0; s_delay = 3;
    send($urandom, 20, ok);
    send($urandom, 20, ok);
    repeat (6) tick();
    s_delay = 20;
    send(32'h11111111, 20, ok);
    repeat (5) tick();
    aclr_n = 1'b0;
    @(negedge clock);
    chk("t7_out_valid", 64'(out_valid), 64'd0);
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_clken", 64'(ci_clk_en), 64'd0);
    chk("t7_in_ready", 64'(in_ready), 64'd0);
    chk("t7_out_data", 64'(out_data), 64'd0);
    sb_q.delete();
    tick();
    aclr_n = 1'b1;
    count_aclr(6, n);
    chk("t7_init_aclr", 64'(n), 64'd1);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (out_valid) n++;
    end
    chk("t7_no_output", 64'(n), 64'd0);
    tick();
    out_ready = 1'b1; s_delay = 3;
    send(32'h3F000000, 10, ok);
    chk("t7_post_accept", 64'(ok), 64'd1);
    drain(30);

    chk("sb_final_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
